// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback on the shared datapath.
// Latency: 2-5 cycles per instruction with MemReady high; Moore outputs follow State the same cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while MemReady is low; HALT parks until reset.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Retire,
    output logic       Halted,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LINK     = 4'd12,
        LUI      = 4'd13,
        HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state_q, state_d;
    logic   halted_q, illegal_q, illegal_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT) halted_q  <= 1'b1;
            if (illegal_d)       illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        Retire    = 1'b0;

        // Immediate format tracks the opcode in every state, matching the single-cycle decoder.
        case (Op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
            OP_JAL:           ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase

        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = ALUWB;
                    OP_SYSTEM:         state_d = HALT;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = MemReady;
                if (MemReady) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = BranchTaken;
                Retire  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                // Target already sits in ALUOut; the ALU computes the link value meanwhile.
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALUWB;
            end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = LINK;
            end
            LINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALUWB;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign Halted  = halted_q;
    assign Illegal = illegal_q;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against an instruction-level sequence model.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] Op;
    logic       BranchTaken;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Halted, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .BranchTaken(BranchTaken), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Retire(Retire), .Halted(Halted),
        .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011, SW   = 7'b0100011, RT  = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011, BR   = 7'b1100011, JL  = 7'b1101111;
    localparam logic [6:0] JR   = 7'b1100111, LU   = 7'b0110111, AU  = 7'b0010111;
    localparam logic [6:0] EBRK = 7'b1110011;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, pcw, adr, mw, rw, ret;
        logic [1:0] rsrc, asa, asb, aluop;
        logic [2:0] imm;
    } obs_t;

    typedef struct {
        obs_t o;
        logic mr;
        logic bt;
    } step_t;

    step_t sq[$];

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == SW) return 3'b001;
        if (op == BR) return 3'b010;
        if (op == LU || op == AU) return 3'b011;
        if (op == JL) return 3'b100;
        return 3'b000;
    endfunction

    function automatic obs_t mk(input logic [3:0] st, input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] aluop, input logic [1:0] rsrc,
                                input logic irw, input logic pcw, input logic adr,
                                input logic mw, input logic rw, input logic ret);
        obs_t o;
        o.st = st; o.asa = asa; o.asb = asb; o.aluop = aluop; o.rsrc = rsrc;
        o.irw = irw; o.pcw = pcw; o.adr = adr; o.mw = mw; o.rw = rw; o.ret = ret;
        o.imm = 3'b000;
        return o;
    endfunction

    function automatic void push(input obs_t o, input logic mr, input logic bt, input logic [6:0] op);
        step_t s;
        s.o = o;
        s.o.imm = imm_of(op);
        s.mr = mr;
        s.bt = bt;
        sq.push_back(s);
    endfunction

    // Reference: the cycle-by-cycle walk one instruction takes, given its wait states.
    function automatic void build(input logic [6:0] op, input logic bt, input int fw, input int mw);
        sq.delete();
        for (int i = 0; i < fw; i++)
            push(mk(0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0), 1'b0, 1'($urandom), op);
        push(mk(0, 2'b00, 2'b10, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0), 1'b1, 1'($urandom), op);
        push(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
        if (op == LW || op == SW)
            push(mk(2, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
        if (op == LW) begin
            for (int i = 0; i < mw; i++)
                push(mk(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0), 1'b0, 1'($urandom), op);
            push(mk(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0), 1'b1, 1'($urandom), op);
            push(mk(4, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 1), 1'($urandom), 1'($urandom), op);
        end else if (op == SW) begin
            for (int i = 0; i < mw; i++)
                push(mk(5, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0), 1'b0, 1'($urandom), op);
            push(mk(5, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 1), 1'b1, 1'($urandom), op);
        end else if (op == BR) begin
            push(mk(9, 2'b10, 2'b00, 2'b01, 2'b00, 0, bt, 0, 0, 0, 1), 1'($urandom), bt, op);
        end else begin
            if (op == RT) push(mk(6, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
            if (op == IT) push(mk(7, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
            if (op == JL) push(mk(10, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
            if (op == JR) begin
                push(mk(11, 2'b10, 2'b01, 2'b00, 2'b10, 0, 1, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
                push(mk(12, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
            end
            if (op == LU) push(mk(13, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), op);
            push(mk(8, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1), 1'($urandom), 1'($urandom), op);
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        MemReady = 1'b1;
        BranchTaken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; Op = 7'd0; BranchTaken = 1'b0; MemReady = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({State, Halted, Illegal, IRWrite, PCWrite} !== {4'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_idle got st=%0d h=%b i=%b irw=%b pcw=%b exp st=0 all 0", State, Halted, Illegal, IRWrite, PCWrite);
        end
        MemReady = 1'b1; #1;
        checks++;
        if ({IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, MemWrite, RegWrite, Retire} !== {3'b110, 2'b00, 2'b10, 2'b10, 3'b000}) begin
            errors++;
            $display("FAIL reset_fetch_outputs got irw=%b pcw=%b adr=%b asa=%b asb=%b rsrc=%b mw=%b rw=%b ret=%b",
                     IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, MemWrite, RegWrite, Retire);
        end
    endtask

    task automatic test_add();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        do_reset();
        Op = RT;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({State, RegWrite, Retire} !== {exp_st[i], (i == 3), (i == 3)}) begin
                errors++;
                $display("FAIL add_cycle%0d got st=%0d rw=%b ret=%b exp st=%0d rw=%b ret=%b", i, State, RegWrite, Retire, exp_st[i], (i == 3), (i == 3));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr     [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        Op = LW;
        for (int i = 0; i < 8; i++) begin
            MemReady = mr[i];
            #1;
            checks++;
            if ({State, AdrSrc, RegWrite, ResultSrc == 2'b01} !== {exp_st[i], exp_st[i] == 4'd3, (i == 6), (i == 6)}) begin
                errors++;
                $display("FAIL lw_cycle%0d got st=%0d adr=%b rw=%b rsrc=%b exp st=%0d", i, State, AdrSrc, RegWrite, ResultSrc, exp_st[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            logic bt;
            logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
            bt = (k == 0);
            do_reset();
            Op = BR;
            for (int i = 0; i < 4; i++) begin
                BranchTaken = (i == 2) ? bt : ~bt;
                #1;
                checks++;
                if (State !== exp_st[i] || (i == 1 && PCWrite !== 1'b0) ||
                    (i == 2 && {PCWrite, ALUOp, Retire} !== {bt, 2'b01, 1'b1})) begin
                    errors++;
                    $display("FAIL branch_bt%0b_cycle%0d got st=%0d pcw=%b aluop=%b ret=%b exp st=%0d", bt, i, State, PCWrite, ALUOp, Retire, exp_st[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jalr();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd8};
        do_reset();
        Op = JR;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (State !== exp_st[i] || (i == 2 && {PCWrite, ResultSrc, RegWrite} !== {1'b1, 2'b10, 1'b0}) ||
                (i == 3 && {ALUSrcA, ALUSrcB, PCWrite, RegWrite} !== {2'b01, 2'b10, 2'b00}) ||
                (i == 4 && {RegWrite, Retire, PCWrite, ResultSrc} !== {3'b110, 2'b00})) begin
                errors++;
                $display("FAIL jalr_cycle%0d got st=%0d pcw=%b rsrc=%b asa=%b asb=%b rw=%b ret=%b exp st=%0d",
                         i, State, PCWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, Retire, exp_st[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [9:0] exp_v;
        do_reset();
        Op = EBRK;
        for (int i = 0; i < 22; i++) begin
            MemReady = (i < 2) ? 1'b1 : 1'($urandom);
            BranchTaken = 1'($urandom);
            #1;
            if (i == 0)      exp_v = {4'd0, 2'b00, 4'b1100};
            else if (i == 1) exp_v = {4'd1, 2'b00, 4'b0000};
            else             exp_v = {4'd14, 2'b10, 4'b0000};
            checks++;
            if ({State, Halted, Illegal, PCWrite, IRWrite, MemWrite, RegWrite | Retire} !== exp_v) begin
                errors++;
                $display("FAIL ebreak_cycle%0d got st=%0d h=%b i=%b pcw=%b irw=%b mw=%b rw=%b ret=%b exp %b",
                         i, State, Halted, Illegal, PCWrite, IRWrite, MemWrite, RegWrite, Retire, exp_v);
            end
            @(posedge clk); #1;
        end
        do_reset();
        Op = 7'b0000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({State, Halted, Illegal} !== {4'd14, 2'b11}) begin
            errors++;
            $display("FAIL illegal_halt got st=%0d h=%b i=%b exp st=14 h=1 i=1", State, Halted, Illegal);
        end
        reset = 1'b1; #1;
        checks++;
        if ({State, Halted, Illegal} !== {4'd0, 2'b00}) begin
            errors++;
            $display("FAIL illegal_reset_clear got st=%0d h=%b i=%b exp st=0 h=0 i=0", State, Halted, Illegal);
        end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        Op = SW;
        for (int i = 0; i < 5; i++) begin
            MemReady = (i < 3) ? 1'b1 : 1'b0;
            #1;
            if (i >= 3) begin
                checks++;
                if ({State, MemWrite, AdrSrc, Retire} !== {4'd5, 3'b110}) begin
                    errors++;
                    $display("FAIL sw_wait_cycle%0d got st=%0d mw=%b adr=%b ret=%b exp st=5 mw=1 adr=1 ret=0", i, State, MemWrite, AdrSrc, Retire);
                end
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1; #1;
        checks++;
        if ({State, MemWrite, RegWrite, Halted, Illegal} !== {4'd0, 4'b0000}) begin
            errors++;
            $display("FAIL midwrite_reset got st=%0d mw=%b rw=%b h=%b i=%b exp st=0 all 0", State, MemWrite, RegWrite, Halted, Illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0; MemReady = 1'b1; #1;
        checks++;
        if ({State, IRWrite, MemWrite} !== {4'd0, 2'b10}) begin
            errors++;
            $display("FAIL midwrite_refetch got st=%0d irw=%b mw=%b exp st=0 irw=1 mw=0", State, IRWrite, MemWrite);
        end
        @(posedge clk); #1; #1;
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL midwrite_resume got st=%0d exp 1", State);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{LW, SW, RT, IT, BR, BR, JL, JR, LU, AU};
        int retires;
        obs_t got;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 9)];
            build(op, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            Op = op;
            retires = 0;
            foreach (sq[j]) begin
                MemReady = sq[j].mr;
                BranchTaken = sq[j].bt;
                #1;
                got = {State, IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, Retire, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
                retires += int'(Retire);
                checks++;
                if (got !== sq[j].o) begin
                    errors++;
                    $display("FAIL rand_op%b_step%0d got %h exp %h (st %0d vs %0d)", op, j, got, sq[j].o, got.st, sq[j].o.st);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (retires != 1) begin
                errors++;
                $display("FAIL rand_retire_count op%b got %0d exp 1", op, retires);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jalr();
        test_halt();
        test_reset_midwrite();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core variant. Sequences the shared datapath (one memory port, one ALU, ALUOut/Data/OldPC holding registers) through fetch, decode and per-class execute/writeback steps, issuing the same ImmSrc/ALUOp encodings the single-cycle decoder uses. Supports memory wait states via a ready handshake and parks in a sticky halt on ebreak or an illegal opcode.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- Op  in  7  opcode from instruction register (valid from DECODE onward)
- BranchTaken  in  1  branch condition from compare unit, sampled in BRANCH
- MemReady  in  1  memory completes access this cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR and OldPC
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 Imm, 10 constant 4
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- RegWrite  out  1  register file write
- Retire  out  1  single-cycle pulse on final cycle of each instruction
- Halted  out  1  sticky, set on entering HALT
- Illegal  out  1  sticky, set when HALT entered via unknown opcode
- State  out  4  current state encoding (debug)

## Operation
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, LUI 13, HALT 14. Encoding 15 unreachable; if reached, go to FETCH.
- Outputs are Moore-decoded from State; only IRWrite, PCWrite, Retire gate on MemReady/BranchTaken. Every output not listed for a state is 0.
- ImmSrc decoded from Op in every state: store 001, branch 010, lui/auipc 011, jal 100, else 000.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10; IRWrite=PCWrite=MemReady. Stay until MemReady, then DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (ALUOut <= OldPC+imm). Next by Op: 0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; 0110111 LUI; 0010111 ALUWB; 1110011 HALT; other HALT with Illegal.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00; hold until MemReady, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1, Retire 1 -> FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1 held until MemReady; Retire=MemReady; -> FETCH on MemReady.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB. EXECI: same with ALUSrcB 01 -> ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1, Retire 1 -> FETCH.
- BRANCH: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00; PCWrite=BranchTaken; Retire 1 -> FETCH.
- JAL: ResultSrc 00, PCWrite 1 (PC <= target in ALUOut); ALUSrcA 01, ALUSrcB 10, ALUOp 00 (link) -> ALUWB.
- JALR: ALUSrcA 10, ALUSrcB 01, ALUOp 00, ResultSrc 10, PCWrite 1 (datapath clears bit 0) -> LINK.
- LINK: ALUSrcA 01, ALUSrcB 10, ALUOp 00 -> ALUWB.
- LUI: ALUSrcA 11, ALUSrcB 01, ALUOp 00 -> ALUWB.
- HALT: all strobes 0; remains until reset. Halted/Illegal clear only on reset.

## Timing
- Reset: State=FETCH, Halted=0, Illegal=0; outputs take FETCH values (IRWrite/PCWrite follow MemReady). Reset mid-instruction abandons it with no write strobes after deassertion except FETCH's.
- Cycles with MemReady tied 1: lw 5, sw 4, R/I-type 4, branch 3, jal 4, jalr 5, lui 4, auipc 3, ebreak 2 then halt.
- Each cycle MemReady=0 in FETCH/MEMREAD/MEMWRITE adds one cycle; MemWrite and AdrSrc stable throughout the wait.
- Exactly one Retire pulse per completed instruction; none for ebreak/illegal.
- BranchTaken is sampled only in BRANCH; MemReady ignored outside FETCH/MEMREAD/MEMWRITE.

## Test plan
- Reset then add (Op 0110011), MemReady=1 -> State 0,1,6,8,0; RegWrite only in cycle 4; Retire one pulse in ALUWB.
- lw with MemReady low 2 cycles in MEMREAD -> State 0,1,2,3,3,3,4,0; AdrSrc=1 for all three MEMREAD cycles; RegWrite+ResultSrc 01 in MEMWB.
- beq with BranchTaken=1 then 0 -> PCWrite 1 in BRANCH only in first case; both 3 cycles, ALUOp 01.
- jalr -> State 0,1,11,12,8; PCWrite in JALR with ResultSrc 10; RegWrite in ALUWB with link sourced from LINK's OldPC+4.
- ebreak (1110011) -> HALT, Halted=1, Illegal=0, no strobes for 20 cycles; Op 0000000 after reset -> HALT, Illegal=1.
- Assert reset in MEMWRITE while MemWrite=1 -> MemWrite drops asynchronously, State=0, Halted/Illegal 0, fetch resumes after release.
